// File: rtl/any1_issue_stage_if.sv
// any1_issue_stage_if: exec-side valid/ready bus carrying the issued ROB slot and its entry snapshot.
interface any1_issue_stage_if #(parameter type T = logic [43:0]);
    logic       v;
    logic       rdy;
    logic [5:0] id;
    T           entry;
    modport master(output v, id, entry, input rdy);
    modport slave(input v, id, entry, output rdy);
endinterface

// File: rtl/any1_issue_stage.sv
// any1_issue_stage: validates scheduler picks, snapshots ROB entries into an in-order queue, issues them.
// Define ANY1_ISSUE_BYPASS_EN to let a pick skip an empty queue straight into the exec register.
package any1_pkg;
    parameter int ROB_ENTRIES = 64;
    typedef struct packed {
        logic        v;
        logic        dec;
        logic        cmt;
        logic        out;
        logic [7:0]  op;
        logic [31:0] pc;
    } sReorderEntry;
endpackage

module any1_issue_stage #(
    parameter int ROB_ENTRIES = any1_pkg::ROB_ENTRIES,
    parameter int QDEPTH = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  any1_pkg::sReorderEntry [ROB_ENTRIES-1:0]     rob,
    input  logic [6:0]                                   selection,
    input  logic                                         flush,
    any1_issue_stage_if.master                           ex,
    output logic                                         set_out,
    output logic [5:0]                                   set_out_id,
    output logic [$clog2(QDEPTH):0]                      q_count,
    output logic [31:0]                                  issued_cnt
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    logic [5:0]             w_sel;
    any1_pkg::sReorderEntry w_ent;
    logic                   w_free, w_pop, w_dup, w_acc, w_byp, w_push;
    logic [5:0]             r_qid [QDEPTH];
    any1_pkg::sReorderEntry r_qe [QDEPTH];
    logic [AW-1:0]          r_head, r_tail;
    logic [CW-1:0]          r_count;
    logic                   r_set_out, r_ev;
    logic [5:0]             r_set_out_id, r_eid;
    any1_pkg::sReorderEntry r_ee;
    logic [31:0]            r_cnt;

    assign w_sel  = selection[5:0];
    assign w_ent  = rob[w_sel];
    assign w_free = !r_ev || ex.rdy;
    assign w_pop  = w_free && r_count != '0;

    // a queue slot is live when its distance from head is below the occupancy
    always_comb begin
        w_dup = r_ev && r_eid == w_sel;
        for (int i = 0; i < QDEPTH; i++)
            w_dup = w_dup || ({1'b0, AW'(i) - r_head} < r_count && r_qid[i] == w_sel);
    end

    assign w_acc = !selection[6] && w_ent.v && w_ent.dec && !w_ent.cmt && !w_ent.out && !flush && !w_dup
                   && (r_count < QFULL || w_pop);
`ifdef ANY1_ISSUE_BYPASS_EN
    assign w_byp = w_acc && r_count == '0 && w_free;
`else
    assign w_byp = 1'b0;
`endif
    assign w_push = w_acc && !w_byp;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ev      <= 1'b0;
            r_set_out <= 1'b0;
        end else begin
            r_set_out <= w_acc;
            if (w_push) begin
                r_qid[r_tail] <= w_sel;
                r_qe[r_tail]  <= w_ent;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_free)
                r_ev <= w_byp || w_pop;
        end
    end

    // payload registers survive a flush; only valid bits and occupancy are cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            r_set_out_id <= '0;
            r_eid        <= '0;
            r_ee         <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_acc)
                r_set_out_id <= w_sel;
            if (w_free && (w_byp || w_pop)) begin
                r_eid <= w_byp ? w_sel : r_qid[r_head];
                r_ee  <= w_byp ? w_ent : r_qe[r_head];
            end
            if (r_ev && ex.rdy)
                r_cnt <= r_cnt + 32'd1;
        end
    end

    assign set_out    = r_set_out;
    assign set_out_id = r_set_out_id;
    assign ex.v       = r_ev;
    assign ex.id      = r_eid;
    assign ex.entry   = r_ee;
    assign q_count    = r_count;
    assign issued_cnt = r_cnt;
endmodule

// File: tb/tb_any1_issue_stage.sv
// tb_any1_issue_stage: directed table plus randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_any1_issue_stage;
    import any1_pkg::*;
    localparam int QD = 4;
`ifdef ANY1_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0, rst = 1'b1, flush = 1'b0;
    sReorderEntry [63:0] rob;
    logic [6:0]        selection = 7'h40;
    logic              set_out;
    logic [5:0]        set_out_id;
    logic [2:0]        q_count;
    logic [31:0]       issued_cnt;

    any1_issue_stage_if #(.T(sReorderEntry)) ex_if();

    any1_issue_stage #(.QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .rob(rob), .selection(selection), .flush(flush), .ex(ex_if),
        .set_out(set_out), .set_out_id(set_out_id), .q_count(q_count), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [5:0] id; sReorderEntry e; } item_t;
    item_t        mq[$];
    bit           m_ev, m_so;
    logic [5:0]   m_eid, m_soid;
    sReorderEntry m_ee;
    int unsigned  m_cnt;
    int           n_cmp = 0, n_bad = 0;

    typedef struct packed { int sel, fl, rdy, so, soid, ev, eid, qc, cnt; } vec_t;
    vec_t tbl [28];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clock: update the model from the inputs, clock the DUT, compare all outputs
    task automatic step(input logic [6:0] s, input logic f, input logic r);
        logic [5:0] id;
        sReorderEntry e;
        bit free, pop, dup, acc, byp;
        item_t it;
        selection = s; flush = f; ex_if.rdy = r;
        id = s[5:0]; e = rob[id];
        if (rst) begin
            mq.delete(); m_ev = 0; m_so = 0; m_soid = '0; m_eid = '0; m_ee = '0; m_cnt = 0;
        end else begin
            free = !m_ev || r;
            if (m_ev && r) m_cnt++;
            dup = m_ev && m_eid == id;
            foreach (mq[i]) if (mq[i].id == id) dup = 1;
            pop = free && mq.size() > 0;
            acc = !s[6] && e.v && e.dec && !e.cmt && !e.out && !f && !dup && (mq.size() < QD || pop);
            if (f) begin
                mq.delete(); m_ev = 0; m_so = 0;
            end else begin
                m_so = acc;
                if (acc) m_soid = id;
                byp = BYP && acc && mq.size() == 0 && free;
                if (free) begin
                    m_ev = byp || pop;
                    if (byp) begin m_eid = id; m_ee = e; end
                    else if (pop) begin m_eid = mq[0].id; m_ee = mq[0].e; void'(mq.pop_front()); end
                end
                if (acc && !byp) begin it.id = id; it.e = e; mq.push_back(it); end
            end
        end
        @(posedge clk); #1;
        chk("set_out", 64'(set_out), 64'(m_so));
        if (m_so) chk("set_out_id", 64'(set_out_id), 64'(m_soid));
        chk("exec_v", 64'(ex_if.v), 64'(m_ev));
        if (m_ev) begin
            chk("exec_id", 64'(ex_if.id), 64'(m_eid));
            chk("exec_entry", 64'(ex_if.entry), 64'(m_ee));
        end
        chk("q_count", 64'(q_count), 64'(mq.size()));
        chk("issued_cnt", 64'(issued_cnt), 64'(m_cnt));
    endtask

    initial begin
        int k;
        ex_if.rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rob[i] = '0;
            if (i < 16) begin
                rob[i].v = 1'b1; rob[i].dec = 1'b1; rob[i].op = 8'(i); rob[i].pc = 32'h1000 + 32'(4 * i);
            end
        end
        rob[7].out = 1'b1;
        rob[15].cmt = 1'b1;
        tbl = '{
            '{'h40,0,1, 0, 0, 0, 0,0,0}, '{'h05,0,1, 1, 5, 0, 0,1,0}, '{'h40,0,1, 0, 0, 1, 5,0,0},
            '{'h40,0,1, 0, 0, 0, 0,0,1}, '{'h07,0,1, 0, 0, 0, 0,0,1}, '{'h0f,0,1, 0, 0, 0, 0,0,1},
            '{'h14,0,1, 0, 0, 0, 0,0,1}, '{'h01,0,0, 1, 1, 0, 0,1,1}, '{'h02,0,0, 1, 2, 1, 1,1,1},
            '{'h02,0,0, 0, 0, 1, 1,1,1}, '{'h03,0,0, 1, 3, 1, 1,2,1}, '{'h04,0,0, 1, 4, 1, 1,3,1},
            '{'h06,0,0, 1, 6, 1, 1,4,1}, '{'h08,0,0, 0, 0, 1, 1,4,1}, '{'h40,0,1, 0, 0, 1, 2,3,2},
            '{'h40,0,1, 0, 0, 1, 3,2,3}, '{'h40,0,1, 0, 0, 1, 4,1,4}, '{'h40,0,1, 0, 0, 1, 6,0,5},
            '{'h40,0,1, 0, 0, 0, 0,0,6}, '{'h09,0,0, 1, 9, 0, 0,1,6}, '{'h0a,0,0, 1,10, 1, 9,1,6},
            '{'h0b,0,0, 1,11, 1, 9,2,6}, '{'h0d,0,0, 1,13, 1, 9,3,6}, '{'h0e,0,0, 1,14, 1, 9,4,6},
            '{'h0c,0,1, 1,12, 1,10,4,7}, '{'h40,0,1, 0, 0, 1,11,3,8}, '{'h09,1,0, 0, 0, 0, 0,0,8},
            '{'h40,0,0, 0, 0, 0, 0,0,8}
        };
        rst = 1'b1;
        step(7'h05, 1'b0, 1'b1);
        step(7'h05, 1'b0, 1'b1);
        chk("rst.set_out_id", 64'(set_out_id), 64'd0);
        chk("rst.exec_id", 64'(ex_if.id), 64'd0);
        chk("rst.exec_entry", 64'(ex_if.entry), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(7'h40, 1'b0, 1'(i % 2));
        chk("idle.q_count", 64'(q_count), 64'd0);
        chk("idle.exec_v", 64'(ex_if.v), 64'd0);
`ifndef ANY1_ISSUE_BYPASS_EN
        for (int i = 0; i < 28; i++) begin
            step(7'(tbl[i].sel), 1'(tbl[i].fl), 1'(tbl[i].rdy));
            chk($sformatf("tbl%0d.set_out", i), 64'(set_out), 64'(tbl[i].so));
            if (tbl[i].so != 0) chk($sformatf("tbl%0d.set_out_id", i), 64'(set_out_id), 64'(tbl[i].soid));
            chk($sformatf("tbl%0d.exec_v", i), 64'(ex_if.v), 64'(tbl[i].ev));
            if (tbl[i].ev != 0) begin
                chk($sformatf("tbl%0d.exec_id", i), 64'(ex_if.id), 64'(tbl[i].eid));
                chk($sformatf("tbl%0d.exec_entry", i), 64'(ex_if.entry), 64'(rob[6'(tbl[i].eid)]));
            end
            chk($sformatf("tbl%0d.q_count", i), 64'(q_count), 64'(tbl[i].qc));
            chk($sformatf("tbl%0d.issued_cnt", i), 64'(issued_cnt), 64'(tbl[i].cnt));
        end
`endif
        for (int c = 0; c < 4000; c++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) begin
                rob[k].v = ($urandom_range(0, 3) != 0);
                rob[k].dec = ($urandom_range(0, 5) != 0);
                rob[k].cmt = ($urandom_range(0, 7) == 0);
                rob[k].out = 1'b0;
                rob[k].op = 8'($urandom);
                rob[k].pc = $urandom;
            end
            rst = ($urandom_range(0, 199) == 0);
            step(($urandom_range(0, 4) == 0) ? 7'h40 : 7'($urandom_range(0, 15)),
                 ($urandom_range(0, 29) == 0),
                 ((c / 64) % 3 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            if (m_so) rob[m_soid].out = 1'b1;
        end
        rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
